tmds_multi_serializer: RTL

//  Multi-channel HDMI/DVI TMDS encoder plus 10:1 serializer on one serialClk domain.
//  Per channel: 8b/10b video (DVI 1.0 TMDS), control, TERC4 data-island and guard-band words.

---
 rtl/tmds_multi_serializer_if.sv | 33 +++
 rtl/tmds_multi_serializer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tmds_multi_serializer_if.sv
// Bus interface for the multi-lane TMDS encoder/serializer.
// Purpose: bundles the per-pixel inputs and the serial/debug outputs so
// the serializer and its driver share one typed connection.
// Signals (NUM_CHANNELS lanes, lane c owns slice [c] of every bus):
//   pixelData   video byte per lane, [8c+7:8c]
//   controlBus  {C1,C0} per lane, [2c+1:2c]
//   auxData     TERC4 nibble per lane, [4c+3:4c]
//   mode        00 control, 01 video, 10 TERC4, 11 guard band
//   pixelStrobe one-cycle pulse marking the edge where inputs are sampled
//   tmdsOut     serial bit per lane
//   tmdsWord    10-bit word currently shifting out, per lane (debug)
// Modports: master drives the pixel inputs, slave is the serializer.
interface tmds_multi_serializer_if #(
    parameter int NUM_CHANNELS = 3
);
    logic [8*NUM_CHANNELS-1:0]  pixelData;
    logic [2*NUM_CHANNELS-1:0]  controlBus;
    logic [4*NUM_CHANNELS-1:0]  auxData;
    logic [1:0]                 mode;
    logic                       pixelStrobe;
    logic [NUM_CHANNELS-1:0]    tmdsOut;
    logic [10*NUM_CHANNELS-1:0] tmdsWord;

    modport master (
        output pixelData, controlBus, auxData, mode,
        input  pixelStrobe, tmdsOut, tmdsWord
    );

    modport slave (
        input  pixelData, controlBus, auxData, mode,
        output pixelStrobe, tmdsOut, tmdsWord
    );
endinterface

// File: rtl/tmds_multi_serializer.sv
// Multi-lane HDMI/DVI TMDS encoder with 10:1 serializer, single serialClk domain.
// Each lane encodes video (DVI 8b/10b with running disparity), control
// tokens, TERC4 data-island nibbles or guard-band words, and shifts the
// 10-bit result out LSB first.  A mod-10 bit counter produces pixelStrobe;
// at the strobe edge the input registers capture a new pixel while the
// shift registers load the encoding of the previously captured pixel.
// Ports:
//   serialClk  serialization clock (10x pixel rate)
//   resetN     synchronous active-low reset
//   bus        slave side of tmds_multi_serializer_if (inputs + serial outputs)
module tmds_multi_serializer #(
    parameter int NUM_CHANNELS = 3
) (
    input logic                    serialClk,
    input logic                    resetN,
    tmds_multi_serializer_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_CTRL  = 2'b00,
        MODE_VIDEO = 2'b01,
        MODE_TERC4 = 2'b10,
        MODE_GUARD = 2'b11
    } mode_e;

    logic [3:0]                 bit_count_q, bit_count_d;
    logic                       strobe_q, strobe_d;
    logic                       load;
    mode_e                      mode_q, mode_d;
    logic [8*NUM_CHANNELS-1:0]  pix_q, pix_d;
    logic [2*NUM_CHANNELS-1:0]  ctl_q, ctl_d;
    logic [4*NUM_CHANNELS-1:0]  aux_q, aux_d;
    logic signed [5:0]          disp_q [NUM_CHANNELS];
    logic signed [5:0]          disp_d [NUM_CHANNELS];
    logic [9:0]                 shift_q [NUM_CHANNELS];
    logic [9:0]                 shift_d [NUM_CHANNELS];
    logic [9:0]                 word_q [NUM_CHANNELS];
    logic [9:0]                 word_d [NUM_CHANNELS];
    logic [9:0]                 enc_word [NUM_CHANNELS];
    logic signed [5:0]          enc_disp [NUM_CHANNELS];
    logic [15:0]                video_res [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]    tmds_out_w;
    logic [10*NUM_CHANNELS-1:0] tmds_word_w;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
        return n;
    endfunction

    // DVI video encoding; returns {new disparity, 10-bit word}.
    // The "-2 when q_m[8] is 0" term is written as an explicit select so the
    // 1-bit inversion is not widened before it is applied.
    function automatic logic [15:0] encode_video(input logic [7:0] d,
                                                 input logic signed [5:0] cnt);
        logic [8:0]        q_m;
        logic              use_xnor;
        logic [3:0]        n1d, n1, n0;
        logic signed [5:0] diff;
        logic signed [5:0] cnt_n;
        logic [9:0]        q_out;
        n1d      = ones8(d);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        q_m      = '0;
        q_m[0]   = d[0];
        for (int i = 1; i < 8; i++)
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ d[i]) : (q_m[i-1] ^ d[i]);
        q_m[8] = ~use_xnor;
        n1     = ones8(q_m[7:0]);
        n0     = 4'd8 - n1;
        diff   = $signed({2'b00, n1}) - $signed({2'b00, n0});
        if ((cnt == 6'sd0) || (n1 == n0)) begin
            q_out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            cnt_n = q_m[8] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 6'sd0) && (n1 > n0)) || ((cnt < 6'sd0) && (n0 > n1))) begin
            q_out = {1'b1, q_m[8], ~q_m[7:0]};
            cnt_n = cnt + (q_m[8] ? 6'sd2 : 6'sd0) - diff;
        end else begin
            q_out = {1'b0, q_m[8], q_m[7:0]};
            cnt_n = cnt - (q_m[8] ? 6'sd0 : 6'sd2) + diff;
        end
        return {cnt_n, q_out};
    endfunction

    function automatic logic [9:0] encode_terc4(input logic [3:0] n);
        logic [9:0] w;
        unique case (n)
            4'h0: w = 10'h29C;  4'h1: w = 10'h263;  4'h2: w = 10'h2E4;  4'h3: w = 10'h2E2;
            4'h4: w = 10'h171;  4'h5: w = 10'h11E;  4'h6: w = 10'h18E;  4'h7: w = 10'h13C;
            4'h8: w = 10'h2CC;  4'h9: w = 10'h139;  4'hA: w = 10'h19C;  4'hB: w = 10'h2C6;
            4'hC: w = 10'h28E;  4'hD: w = 10'h271;  4'hE: w = 10'h163;  default: w = 10'h2C3;
        endcase
        return w;
    endfunction

    function automatic logic [9:0] encode_ctrl(input logic [1:0] c);
        logic [9:0] w;
        unique case (c)
            2'b00:   w = 10'h354;
            2'b01:   w = 10'h0AB;
            2'b10:   w = 10'h154;
            default: w = 10'h2AB;
        endcase
        return w;
    endfunction

    // Next-state logic: the strobe edge (bit_count_q == 9) is the only point
    // where a new word is loaded, disparity moves and inputs are captured;
    // every other edge just shifts.  Only video keeps its running disparity.
    always_comb begin
        load        = (bit_count_q == 4'd9);
        bit_count_d = load ? 4'd0 : bit_count_q + 4'd1;
        strobe_d    = (bit_count_d == 4'd9);
        mode_d      = load ? mode_e'(bus.mode) : mode_q;
        pix_d       = load ? bus.pixelData : pix_q;
        ctl_d       = load ? bus.controlBus : ctl_q;
        aux_d       = load ? bus.auxData : aux_q;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            video_res[c] = encode_video(pix_q[8*c +: 8], disp_q[c]);
            enc_disp[c]  = 6'sd0;
            unique case (mode_q)
                MODE_VIDEO: begin
                    enc_word[c] = video_res[c][9:0];
                    enc_disp[c] = $signed(video_res[c][15:10]);
                end
                MODE_TERC4: enc_word[c] = encode_terc4(aux_q[4*c +: 4]);
                MODE_GUARD: enc_word[c] = ((c % 2) == 0) ? 10'h2CC : 10'h133;
                default:    enc_word[c] = encode_ctrl(ctl_q[2*c +: 2]);
            endcase
            shift_d[c] = load ? enc_word[c] : {1'b0, shift_q[c][9:1]};
            word_d[c]  = load ? enc_word[c] : word_q[c];
            disp_d[c]  = load ? enc_disp[c] : disp_q[c];
        end
    end

    // State registers; reset restarts word alignment and idles every lane
    // on the 0x354 control token.
    always_ff @(posedge serialClk) begin
        if (!resetN) begin
            bit_count_q <= 4'd0;
            strobe_q    <= 1'b0;
            mode_q      <= MODE_CTRL;
            pix_q       <= '0;
            ctl_q       <= '0;
            aux_q       <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                shift_q[c] <= 10'h354;
                word_q[c]  <= 10'h354;
                disp_q[c]  <= 6'sd0;
            end
        end else begin
            bit_count_q <= bit_count_d;
            strobe_q    <= strobe_d;
            mode_q      <= mode_d;
            pix_q       <= pix_d;
            ctl_q       <= ctl_d;
            aux_q       <= aux_d;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                shift_q[c] <= shift_d[c];
                word_q[c]  <= word_d[c];
                disp_q[c]  <= disp_d[c];
            end
        end
    end

    // Pack per-lane serial bit and debug word onto the interface buses.
    always_comb begin
        tmds_out_w  = '0;
        tmds_word_w = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            tmds_out_w[c]           = shift_q[c][0];
            tmds_word_w[10*c +: 10] = word_q[c];
        end
    end

    assign bus.pixelStrobe = strobe_q;
    assign bus.tmdsOut     = tmds_out_w;
    assign bus.tmdsWord    = tmds_word_w;
endmodule
